cpu_controller: RTL and testbench

Instruction-sequencing FSM for the 16-bit CPU. It fetches each instruction from memory into the datapath's instruction register, advances the PC, and decodes the opcode. It then drives the register file, ALU/shifter and memory-interface control lines, one state per datapath step, until the instruction retires. It sits beside the datapath inside the CPU top level and is the only block that issues load, write and memory commands.

---
 rtl/cpu_controller.sv | 170 +++++++++++++++++
 tb/tb_cpu_controller.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_controller.sv
// Instruction-sequencing Moore FSM for the 16-bit CPU; outputs are registered alongside the state.
// Outputs change at the same edge as the state, and there is no backpressure: one datapath step per cycle.
module cpu_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic [2:0] nsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic [1:0] vsel,
  output logic       load_ir,
  output logic       load_pc,
  output logic       reset_pc,
  output logic       load_addr,
  output logic       addr_sel,
  output logic [1:0] mem_cmd,
  output logic       instr_done,
  output logic       halted,
  output logic       illegal
);

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPDATE_PC, S_DECODE, S_WR_IMM, S_GET_A, S_GET_B,
    S_EXEC, S_EXEC_Z, S_WR_RD, S_CMP_S, S_ADDR, S_LD_ADDR, S_RD1, S_RD2,
    S_GET_RD, S_PASS_RD, S_MEM_WR, S_HALT_E, S_HALT, S_ILL_E, S_ILL
  } state_t;

  typedef struct packed {
    logic [2:0] nsel;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] vsel;
    logic       load_ir;
    logic       load_pc;
    logic       reset_pc;
    logic       load_addr;
    logic       addr_sel;
    logic [1:0] mem_cmd;
    logic       instr_done;
    logic       halted;
    logic       illegal;
  } ctl_t;

  localparam logic [4:0] I_MOVI = 5'b110_10;
  localparam logic [4:0] I_MOVR = 5'b110_00;
  localparam logic [4:0] I_ADD  = 5'b101_00;
  localparam logic [4:0] I_CMP  = 5'b101_01;
  localparam logic [4:0] I_AND  = 5'b101_10;
  localparam logic [4:0] I_MVN  = 5'b101_11;
  localparam logic [4:0] I_LDR  = 5'b011_00;
  localparam logic [4:0] I_STR  = 5'b100_00;

  // Halt and illegal-halt each have an entry state so instr_done pulses exactly once.
  function automatic ctl_t decode_state(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_RST:       begin c.reset_pc = 1'b1; c.load_pc = 1'b1; end
      S_IF1:       begin c.addr_sel = 1'b1; c.mem_cmd = 2'b01; end
      S_IF2:       begin c.addr_sel = 1'b1; c.mem_cmd = 2'b01; c.load_ir = 1'b1; end
      S_UPDATE_PC: c.load_pc = 1'b1;
      S_WR_IMM:    begin c.nsel = 3'b001; c.vsel = 2'b10; c.write = 1'b1; c.instr_done = 1'b1; end
      S_GET_A:     begin c.nsel = 3'b001; c.loada = 1'b1; end
      S_GET_B:     begin c.nsel = 3'b100; c.loadb = 1'b1; end
      S_EXEC:      c.loadc = 1'b1;
      S_EXEC_Z:    begin c.loadc = 1'b1; c.asel = 1'b1; end
      S_WR_RD:     begin c.nsel = 3'b010; c.vsel = 2'b00; c.write = 1'b1; c.instr_done = 1'b1; end
      S_CMP_S:     begin c.loads = 1'b1; c.instr_done = 1'b1; end
      S_ADDR:      begin c.bsel = 1'b1; c.loadc = 1'b1; end
      S_LD_ADDR:   c.load_addr = 1'b1;
      S_RD1:       c.mem_cmd = 2'b01;
      S_RD2:       begin
        c.mem_cmd = 2'b01; c.nsel = 3'b010; c.vsel = 2'b11;
        c.write = 1'b1; c.instr_done = 1'b1;
      end
      S_GET_RD:    begin c.nsel = 3'b010; c.loadb = 1'b1; end
      S_PASS_RD:   begin c.asel = 1'b1; c.loadc = 1'b1; end
      S_MEM_WR:    begin c.mem_cmd = 2'b10; c.instr_done = 1'b1; end
      S_HALT_E:    begin c.halted = 1'b1; c.instr_done = 1'b1; end
      S_HALT:      c.halted = 1'b1;
      S_ILL_E:     begin c.halted = 1'b1; c.illegal = 1'b1; c.instr_done = 1'b1; end
      S_ILL:       begin c.halted = 1'b1; c.illegal = 1'b1; end
      default:     c = '0;
    endcase
    return c;
  endfunction

  state_t     state_q, state_d;
  ctl_t       ctl_q, ctl_d;
  logic [4:0] instr;

  assign instr = {opcode, op};

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:       state_d = S_IF1;
      S_IF1:       state_d = S_IF2;
      S_IF2:       state_d = S_UPDATE_PC;
      S_UPDATE_PC: state_d = S_DECODE;
      S_DECODE: begin
        case (instr)
          I_MOVI:               state_d = S_WR_IMM;
          I_MOVR, I_MVN:        state_d = S_GET_B;
          I_ADD, I_AND, I_CMP:  state_d = S_GET_A;
          I_LDR, I_STR:         state_d = S_GET_A;
          default:              state_d = (opcode == 3'b111) ? S_HALT_E : S_ILL_E;
        endcase
      end
      S_GET_A:     state_d = (instr == I_LDR || instr == I_STR) ? S_ADDR : S_GET_B;
      S_GET_B: begin
        if (instr == I_CMP)                         state_d = S_CMP_S;
        else if (instr == I_MOVR || instr == I_MVN) state_d = S_EXEC_Z;
        else                                        state_d = S_EXEC;
      end
      S_EXEC, S_EXEC_Z: state_d = S_WR_RD;
      S_ADDR:      state_d = S_LD_ADDR;
      S_LD_ADDR:   state_d = (instr == I_LDR) ? S_RD1 : S_GET_RD;
      S_RD1:       state_d = S_RD2;
      S_GET_RD:    state_d = S_PASS_RD;
      S_PASS_RD:   state_d = S_MEM_WR;
      S_WR_IMM, S_WR_RD, S_CMP_S, S_RD2, S_MEM_WR: state_d = S_IF1;
      S_HALT_E, S_HALT: state_d = S_HALT;
      S_ILL_E, S_ILL:   state_d = S_ILL;
      default:     state_d = S_RST;
    endcase
    ctl_d = decode_state(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RST;
      ctl_q   <= decode_state(S_RST);
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
    end
  end

  assign nsel       = ctl_q.nsel;
  assign write      = ctl_q.write;
  assign loada      = ctl_q.loada;
  assign loadb      = ctl_q.loadb;
  assign loadc      = ctl_q.loadc;
  assign loads      = ctl_q.loads;
  assign asel       = ctl_q.asel;
  assign bsel       = ctl_q.bsel;
  assign vsel       = ctl_q.vsel;
  assign load_ir    = ctl_q.load_ir;
  assign load_pc    = ctl_q.load_pc;
  assign reset_pc   = ctl_q.reset_pc;
  assign load_addr  = ctl_q.load_addr;
  assign addr_sel   = ctl_q.addr_sel;
  assign mem_cmd    = ctl_q.mem_cmd;
  assign instr_done = ctl_q.instr_done;
  assign halted     = ctl_q.halted;
  assign illegal    = ctl_q.illegal;

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: each applied cycle queues its expected output word,
// and a negedge monitor pops and compares against the DUT.
module tb_cpu_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] opcode = 3'b000;
  logic [1:0] op = 2'b00;
  logic [2:0] nsel;
  logic       write, loada, loadb, loadc, loads, asel, bsel;
  logic [1:0] vsel;
  logic       load_ir, load_pc, reset_pc, load_addr, addr_sel;
  logic [1:0] mem_cmd;
  logic       instr_done, halted, illegal;

  cpu_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .op(op),
    .nsel(nsel), .write(write), .loada(loada), .loadb(loadb), .loadc(loadc),
    .loads(loads), .asel(asel), .bsel(bsel), .vsel(vsel), .load_ir(load_ir),
    .load_pc(load_pc), .reset_pc(reset_pc), .load_addr(load_addr),
    .addr_sel(addr_sel), .mem_cmd(mem_cmd), .instr_done(instr_done),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Output word: nsel[21:19] write loada loadb loadc loads asel bsel vsel[11:10]
  // load_ir load_pc reset_pc load_addr addr_sel mem_cmd[4:3] instr_done halted illegal
  logic [21:0] act;
  assign act = {nsel, write, loada, loadb, loadc, loads, asel, bsel, vsel, load_ir,
                load_pc, reset_pc, load_addr, addr_sel, mem_cmd, instr_done, halted, illegal};

  localparam logic [21:0] N_RN = 22'd1 << 19, N_RD = 22'd2 << 19, N_RM = 22'd4 << 19;
  localparam logic [21:0] WR = 22'd1 << 18, LA = 22'd1 << 17, LB = 22'd1 << 16;
  localparam logic [21:0] LC = 22'd1 << 15, LS = 22'd1 << 14, AS = 22'd1 << 13, BS = 22'd1 << 12;
  localparam logic [21:0] V_IMM = 22'd2 << 10, V_MD = 22'd3 << 10;
  localparam logic [21:0] LIR = 22'd1 << 9, LPC = 22'd1 << 8, RPC = 22'd1 << 7;
  localparam logic [21:0] LAD = 22'd1 << 6, ASL = 22'd1 << 5;
  localparam logic [21:0] M_RD = 22'd1 << 3, M_WR = 22'd2 << 3;
  localparam logic [21:0] DONE = 22'd1 << 2, HLT = 22'd1 << 1, ILL = 22'd1;

  localparam logic [21:0] E_RST   = LPC | RPC;
  localparam logic [21:0] E_IF1   = ASL | M_RD;
  localparam logic [21:0] E_IF2   = ASL | M_RD | LIR;
  localparam logic [21:0] E_UPC   = LPC;
  localparam logic [21:0] E_DEC   = 22'd0;
  localparam logic [21:0] E_WRIMM = N_RN | V_IMM | WR | DONE;
  localparam logic [21:0] E_GETA  = N_RN | LA;
  localparam logic [21:0] E_GETB  = N_RM | LB;
  localparam logic [21:0] E_EX    = LC;
  localparam logic [21:0] E_EXZ   = LC | AS;
  localparam logic [21:0] E_WRRD  = N_RD | WR | DONE;
  localparam logic [21:0] E_CMPS  = LS | DONE;
  localparam logic [21:0] E_ADDR  = BS | LC;
  localparam logic [21:0] E_LDA   = LAD;
  localparam logic [21:0] E_RD1   = M_RD;
  localparam logic [21:0] E_RD2   = M_RD | N_RD | V_MD | WR | DONE;
  localparam logic [21:0] E_GETRD = N_RD | LB;
  localparam logic [21:0] E_PASS  = AS | LC;
  localparam logic [21:0] E_MEMWR = M_WR | DONE;
  localparam logic [21:0] E_HLTE  = HLT | DONE;
  localparam logic [21:0] E_HLT   = HLT;
  localparam logic [21:0] E_ILLE  = HLT | ILL | DONE;
  localparam logic [21:0] E_ILL   = HLT | ILL;

  typedef struct {
    logic [21:0] exp;
    string       name;
  } sb_t;

  sb_t sb_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      sb_t it;
      it = sb_q.pop_front();
      n_cmp++;
      if (act !== it.exp) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b", it.name, act, it.exp);
      end
    end
  end

  // Apply inputs for the coming edge, then queue the output expected after it.
  task automatic step(input logic r, input logic [2:0] oc, input logic [1:0] o,
                      input logic [21:0] e, input string nm);
    rst = r; opcode = oc; op = o;
    @(posedge clk);
    #1;
    sb_q.push_back('{exp: e, name: nm});
  endtask

  task automatic fetch(input logic [2:0] oc, input logic [1:0] o, input string nm);
    step(1'b0, oc, o, E_IF1, {nm, "_if1"});
    step(1'b0, oc, o, E_IF2, {nm, "_if2"});
    step(1'b0, oc, o, E_UPC, {nm, "_upc"});
    step(1'b0, oc, o, E_DEC, {nm, "_dec"});
  endtask

  initial begin
    step(1'b1, 3'b000, 2'b00, E_RST, "rst0");
    step(1'b1, 3'b000, 2'b00, E_RST, "rst1");

    fetch(3'b110, 2'b10, "movi");
    step(1'b0, 3'b110, 2'b10, E_WRIMM, "movi_wr");

    fetch(3'b101, 2'b00, "add");
    step(1'b0, 3'b101, 2'b00, E_GETA, "add_geta");
    step(1'b0, 3'b101, 2'b00, E_GETB, "add_getb");
    step(1'b0, 3'b101, 2'b00, E_EX,   "add_exec");
    step(1'b0, 3'b101, 2'b00, E_WRRD, "add_wr");

    fetch(3'b101, 2'b01, "cmp");
    step(1'b0, 3'b101, 2'b01, E_GETA, "cmp_geta");
    step(1'b0, 3'b101, 2'b01, E_GETB, "cmp_getb");
    step(1'b0, 3'b101, 2'b01, E_CMPS, "cmp_s");

    fetch(3'b110, 2'b00, "movr");
    step(1'b0, 3'b110, 2'b00, E_GETB, "movr_getb");
    step(1'b0, 3'b110, 2'b00, E_EXZ,  "movr_exec");
    step(1'b0, 3'b110, 2'b00, E_WRRD, "movr_wr");

    fetch(3'b101, 2'b11, "mvn");
    step(1'b0, 3'b101, 2'b11, E_GETB, "mvn_getb");
    step(1'b0, 3'b101, 2'b11, E_EXZ,  "mvn_exec");
    step(1'b0, 3'b101, 2'b11, E_WRRD, "mvn_wr");

    fetch(3'b101, 2'b10, "and");
    step(1'b0, 3'b101, 2'b10, E_GETA, "and_geta");
    step(1'b0, 3'b101, 2'b10, E_GETB, "and_getb");
    step(1'b0, 3'b101, 2'b10, E_EX,   "and_exec");
    step(1'b0, 3'b101, 2'b10, E_WRRD, "and_wr");

    fetch(3'b011, 2'b00, "ldr");
    step(1'b0, 3'b011, 2'b00, E_GETA, "ldr_geta");
    step(1'b0, 3'b011, 2'b00, E_ADDR, "ldr_addr");
    step(1'b0, 3'b011, 2'b00, E_LDA,  "ldr_ldaddr");
    step(1'b0, 3'b011, 2'b00, E_RD1,  "ldr_rd1");
    step(1'b0, 3'b011, 2'b00, E_RD2,  "ldr_rd2");

    fetch(3'b100, 2'b00, "str");
    step(1'b0, 3'b100, 2'b00, E_GETA,  "str_geta");
    step(1'b0, 3'b100, 2'b00, E_ADDR,  "str_addr");
    step(1'b0, 3'b100, 2'b00, E_LDA,   "str_ldaddr");
    step(1'b0, 3'b100, 2'b00, E_GETRD, "str_getrd");
    step(1'b0, 3'b100, 2'b00, E_PASS,  "str_pass");
    step(1'b0, 3'b100, 2'b00, E_MEMWR, "str_memwr");

    fetch(3'b111, 2'b01, "halt");
    step(1'b0, 3'b111, 2'b01, E_HLTE, "halt_entry");
    for (int i = 0; i < 20; i++) step(1'b0, 3'b111, 2'b01, E_HLT, "halt_hold");
    step(1'b1, 3'b111, 2'b01, E_RST, "halt_rst");

    fetch(3'b000, 2'b00, "ill000");
    step(1'b0, 3'b000, 2'b00, E_ILLE, "ill_entry");
    for (int i = 0; i < 4; i++) step(1'b0, 3'b000, 2'b00, E_ILL, "ill_hold");
    step(1'b1, 3'b000, 2'b00, E_RST, "ill_rst");

    fetch(3'b110, 2'b01, "ill110");
    step(1'b0, 3'b110, 2'b01, E_ILLE, "ill110_entry");
    step(1'b1, 3'b110, 2'b01, E_RST,  "ill110_rst");

    fetch(3'b100, 2'b00, "strx");
    step(1'b0, 3'b100, 2'b00, E_GETA,  "strx_geta");
    step(1'b0, 3'b100, 2'b00, E_ADDR,  "strx_addr");
    step(1'b0, 3'b100, 2'b00, E_LDA,   "strx_ldaddr");
    step(1'b0, 3'b100, 2'b00, E_GETRD, "strx_getrd");
    step(1'b0, 3'b100, 2'b00, E_PASS,  "strx_pass");
    step(1'b1, 3'b100, 2'b00, E_RST,   "strx_rst");
    step(1'b1, 3'b100, 2'b00, E_RST,   "strx_rst_hold");
    step(1'b0, 3'b100, 2'b00, E_IF1,   "strx_if1");

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: got %0d entries left expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
